// File: rtl/pipe_mem_stall_ctrl_if.sv
// Signal bundle between the 2-stage pipeline and its memory stall controller.
// The pipeline side drives the stage-2 access description and debug controls.
interface pipe_mem_stall_ctrl_if #(
  parameter int CNT_BITS = 16
);
  logic                ex_valid;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic [31:0]         ex_addr;
  logic                halt_req;
  logic                step;
  logic                cnt_clr;
  logic                pc_wrt_en;
  logic                pipe_en;
  logic                rf_wrt_gate;
  logic                dmem_wrt_gate;
  logic                halted;
  logic [CNT_BITS-1:0] stall_cnt;

  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_addr, halt_req, step, cnt_clr,
    input  pc_wrt_en, pipe_en, rf_wrt_gate, dmem_wrt_gate, halted, stall_cnt
  );

  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_addr, halt_req, step, cnt_clr,
    output pc_wrt_en, pipe_en, rf_wrt_gate, dmem_wrt_gate, halted, stall_cnt
  );
endinterface

// File: rtl/pipe_mem_stall_ctrl.sv
// Freezes both pipeline stages while the stage-2 instruction waits on RAM or I/O,
// and provides debug halt / single-step.
module pipe_mem_stall_ctrl #(
  parameter logic [31:0] IO_BASE    = 32'hF0000000,
  parameter logic [31:0] IO_MASK    = 32'hF0000000,
  parameter int          MEM_RD_LAT = 1,
  parameter int          MEM_WR_LAT = 0,
  parameter int          IO_RD_LAT  = 3,
  parameter int          IO_WR_LAT  = 2,
  parameter int          CNT_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_mem_stall_ctrl_if.slave bus
);

  localparam logic [3:0] MemRdLat = 4'(MEM_RD_LAT);
  localparam logic [3:0] MemWrLat = 4'(MEM_WR_LAT);
  localparam logic [3:0] IoRdLat  = 4'(IO_RD_LAT);
  localparam logic [3:0] IoWrLat  = 4'(IO_WR_LAT);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              state, nextState;
  logic [3:0]          cnt, nextCnt;
  logic [CNT_BITS-1:0] stallCnt;
  logic                stallInc;
  logic                isIo, rdAcc, wrAcc;
  logic [3:0]          lat;
  logic                pcEn, pipeEn, rfGate, dmemGate;

  // A load wins over a simultaneous store; the store half is then dropped.
  always_comb begin
    isIo  = ((bus.ex_addr & IO_MASK) == IO_BASE);
    rdAcc = bus.ex_valid & bus.ex_mem_read;
    wrAcc = bus.ex_valid & bus.ex_mem_write & ~bus.ex_mem_read;
    lat   = 4'd0;
    if (rdAcc)      lat = isIo ? IoRdLat : MemRdLat;
    else if (wrAcc) lat = isIo ? IoWrLat : MemWrLat;
  end

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    stallInc  = 1'b0;
    pcEn      = 1'b0;
    pipeEn    = 1'b0;
    rfGate    = 1'b0;
    dmemGate  = 1'b0;
    case (state)
      ST_WAIT: begin
        if (cnt > 4'd1) begin
          nextCnt  = cnt - 4'd1;
          stallInc = 1'b1;
        end else begin
          pcEn      = 1'b1;
          pipeEn    = 1'b1;
          rfGate    = 1'b1;
          nextCnt   = 4'd0;
          nextState = bus.halt_req ? ST_HALT : ST_RUN;
        end
      end
      default: begin
        // A single-step cycle out of HALT is an ordinary RUN cycle.
        if (state == ST_RUN || bus.step) begin
          if (lat == 4'd0) begin
            pcEn      = 1'b1;
            pipeEn    = 1'b1;
            rfGate    = 1'b1;
            dmemGate  = ~(bus.ex_valid & bus.ex_mem_read & bus.ex_mem_write);
            nextState = bus.halt_req ? ST_HALT : ST_RUN;
          end else begin
            // The store strobe goes out once, in the entry cycle of the stall.
            dmemGate  = wrAcc;
            nextCnt   = lat;
            nextState = ST_WAIT;
            stallInc  = 1'b1;
          end
        end else begin
          nextState = bus.halt_req ? ST_HALT : ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      cnt      <= 4'd0;
      stallCnt <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (bus.cnt_clr)
        stallCnt <= '0;
      else if (stallInc && !(&stallCnt))
        stallCnt <= stallCnt + 1'b1;
    end
  end

  assign bus.pc_wrt_en     = pcEn & ~reset;
  assign bus.pipe_en       = pipeEn & ~reset;
  assign bus.rf_wrt_gate   = rfGate & ~reset;
  assign bus.dmem_wrt_gate = dmemGate & ~reset;
  assign bus.halted        = (state == ST_HALT) & ~reset;
  assign bus.stall_cnt     = stallCnt;

endmodule
